fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the MIPS instruction-fetch stage. Owns the program counter, drives a request/acknowledge handshake to instruction memory, and computes PC+4. Applies branch/jump redirects and decode-stage stalls, and delivers {instruction, pc, pc+4, valid} into the IF/ID boundary. Sits between the instruction memory and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept; current if_* outputs must hold
- redirect  in  1  branch/jump taken this cycle
- redirect_pc  in  32  target address; bits [1:0] ignored and forced to 0
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle; valid only while imem_req=1
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_instr/if_pc/if_pc_4 hold a live instruction
- if_instr  out  32  fetched instruction
- if_pc  out  32  address of if_instr
- if_pc_4  out  32  if_pc + 4

## Operation
- State register fetch_state_t has the states IDLE, FETCH, HOLD and DROP. The controller keeps three internal registers: pc, imem_addr_q and a one-entry skid buffer {buf_instr, buf_pc}.
- imem_req is 1 in FETCH and DROP and 0 elsewhere. imem_addr equals imem_addr_q.
- Handshake: once imem_req=1, the controller holds imem_req and imem_addr unchanged until imem_ack. imem_ack may arrive in the same cycle as the request.
- The output slot is free when !if_valid || !stall.
- IDLE: the state after reset. It moves to FETCH unconditionally on the next cycle.
- FETCH with imem_ack and the slot free: load if_instr=imem_rdata, if_pc=imem_addr_q, if_pc_4=imem_addr_q+4 and if_valid=1. Set pc and imem_addr_q to pc+4. Stay in FETCH.
- FETCH with imem_ack and the slot busy: capture the word into the skid buffer and go to HOLD.
- FETCH without imem_ack: stay. If the slot is free, clear if_valid, because the consumer took the previous instruction.
- HOLD: imem_req=0. When stall=0, move the buffer to the if_* outputs (if_valid=1), advance pc and imem_addr_q by 4, and go to FETCH.
- Redirect has the highest priority, in every state, over both stall and ack.
  - In all states: clear if_valid next cycle, set pc to redirect_pc, and discard the skid buffer.
  - FETCH with imem_ack in the same cycle: discard the data, set imem_addr_q to the target, go to FETCH.
  - FETCH without imem_ack: go to DROP and keep imem_addr_q unchanged, because a request is outstanding.
  - HOLD or IDLE: set imem_addr_q to the target and go to FETCH.
  - DROP: overwrite the latched target and stay in DROP.
- DROP: wait for imem_ack and discard imem_rdata. Then set imem_addr_q to pc and go to FETCH. if_valid stays 0 throughout DROP.
- Arithmetic: all PC arithmetic is unsigned 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=32'h0000_0000 (NOP), if_pc=0, if_pc_4=0, state=IDLE.
- The first imem_req=1 appears in the second cycle after rst deasserts.
- Latency: imem_ack in cycle N makes if_valid=1 in cycle N+1.
- Throughput: one instruction per cycle when imem_ack is combinational with imem_req and there is no stall.
- Redirect in cycle N: if_valid=0 in N+1. The target address is issued in N+1, or in the cycle after the outstanding ack when the controller is in DROP.
- rst mid-transaction abandons any outstanding request. The instruction memory is reset by the same rst.
- stall while if_valid=0 has no effect.

## Structure
- Shared package mips_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, HOLD, DROP}
  - INSTR_NOP = 32'h0000_0000
  - PC_INCR = 32'd4
  - default RESET_PC
- Sub-module fetch_skid_buffer: a one-entry {instr, pc} register with load/flush/valid. All other logic stays in fetch_controller.

## Test plan
- Reset then zero-wait memory (imem_ack = imem_req) → imem_addr sequence 0, 4, 8, 12. The if_pc sequence is the same one cycle later, with if_valid continuously 1.
- stall held for 3 cycles while the ack for addr 8 arrives → if_pc stays 4, state is HOLD and imem_req=0. After stall drops, if_pc=8 and fetch resumes at 12.
- 2-cycle wait memory, redirect to 32'h0000_0100 during the outstanding request at 0x10 → DROP. The data from 0x10 never appears on if_*. The next imem_addr is 0x100 and the first valid if_pc is 0x100.
- redirect and stall asserted together while if_valid=1 → if_valid=0 next cycle and the next fetch address is the target.
- pc=32'hFFFF_FFFC fetch → if_pc_4=0 and the next imem_addr is 0.
- rst asserted while in DROP → all outputs take their reset values next edge. The first fetch after reset is at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the MIPS front-end blocks:
//   fetch_state_t : fetch sequencer states
//   INSTR_NOP     : all-zero word (sll $0,$0,0), used as the empty instruction
//   PC_INCR       : sequential PC step
//   RESET_PC      : default first fetch address after reset
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // Word-align a fetch target by forcing the two byte-offset bits to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry {instr, pc} holding register. Catches a returned instruction word
// when the IF/ID slot is still occupied, so the memory handshake can complete
// without waiting for decode.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   load              capture instr_in/pc_in, mark the entry valid
//   flush             drop the entry (wins over load)
//   instr_in, pc_in   word and its address to capture
//   buf_valid         entry holds a word
//   buf_instr, buf_pc captured word and its address
// -----------------------------------------------------------------------------
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        buf_valid,
  output logic [31:0] buf_instr,
  output logic [31:0] buf_pc
);

  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;

  // Entry storage: flush clears, load captures, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_r <= 1'b0;
      instr_r <= INSTR_NOP;
      pc_r    <= 32'h0000_0000;
    end else if (load) begin
      valid_r <= 1'b1;
      instr_r <= instr_in;
      pc_r    <= pc_in;
    end else begin
      valid_r <= valid_r;
      instr_r <= instr_r;
      pc_r    <= pc_r;
    end
  end

  assign buf_valid = valid_r;
  assign buf_instr = instr_r;
  assign buf_pc    = pc_r;

endmodule

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// MIPS instruction-fetch sequencer. Owns the PC, runs a req/ack handshake to
// instruction memory and presents {instr, pc, pc+4, valid} to decode.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall                    decode cannot accept; if_* must hold
//   redirect, redirect_pc    taken branch/jump and its target (bits [1:0] ignored)
//   imem_req, imem_addr      fetch request and address (stable until ack)
//   imem_ack, imem_rdata     memory response, meaningful only while imem_req=1
//   if_valid, if_instr,
//   if_pc, if_pc_4           IF/ID boundary outputs
// -----------------------------------------------------------------------------
module fetch_controller
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  imem_addr_r;
  logic         imem_req_r;
  logic         if_valid_r;
  logic [31:0]  if_instr_r;
  logic [31:0]  if_pc_r;
  logic [31:0]  if_pc_4_r;

  logic         ack_s;
  logic         slot_free_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_next_s;
  logic         buf_load_s;
  logic         buf_flush_s;
  logic         buf_valid_s;
  logic [31:0]  buf_instr_s;
  logic [31:0]  buf_pc_s;

  // Handshake qualifiers and next-address arithmetic (wraps modulo 2^32).
  always_comb begin
    ack_s       = imem_ack && imem_req_r;
    slot_free_s = !if_valid_r || !stall;
    target_s    = word_align(redirect_pc);
    pc_next_s   = pc_r + PC_INCR;
  end

  // Skid-buffer control: capture on a blocked ack, drop on redirect or drain.
  always_comb begin
    buf_load_s  = 1'b0;
    buf_flush_s = 1'b0;
    if (redirect) begin
      buf_flush_s = 1'b1;
    end else begin
      case (state_r)
        FETCH:   buf_load_s  = ack_s && !slot_free_s;
        HOLD:    buf_flush_s = !stall;
        default: buf_load_s  = 1'b0;
      endcase
    end
  end

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load_s),
    .flush     (buf_flush_s),
    .instr_in  (imem_rdata),
    .pc_in     (imem_addr_r),
    .buf_valid (buf_valid_s),
    .buf_instr (buf_instr_s),
    .buf_pc    (buf_pc_s)
  );

  // Fetch sequencer: state, PC, request and IF/ID outputs all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      imem_addr_r <= RESET_PC;
      imem_req_r  <= 1'b0;
      if_valid_r  <= 1'b0;
      if_instr_r  <= INSTR_NOP;
      if_pc_r     <= 32'h0000_0000;
      if_pc_4_r   <= 32'h0000_0000;
    end else if (redirect) begin
      // Redirect beats stall and ack; the request stays up in every outcome.
      if_valid_r <= 1'b0;
      pc_r       <= target_s;
      imem_req_r <= 1'b1;
      case (state_r)
        FETCH: begin
          if (ack_s) begin
            imem_addr_r <= target_s;
            state_r     <= FETCH;
          end else begin
            // Outstanding request must finish at its old address first.
            state_r <= DROP;
          end
        end
        DROP:    state_r <= DROP;
        default: begin
          imem_addr_r <= target_s;
          state_r     <= FETCH;
        end
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          state_r    <= FETCH;
          imem_req_r <= 1'b1;
        end
        FETCH: begin
          if (ack_s && slot_free_s) begin
            if_valid_r  <= 1'b1;
            if_instr_r  <= imem_rdata;
            if_pc_r     <= imem_addr_r;
            if_pc_4_r   <= imem_addr_r + PC_INCR;
            pc_r        <= pc_next_s;
            imem_addr_r <= pc_next_s;
          end else if (ack_s) begin
            state_r    <= HOLD;
            imem_req_r <= 1'b0;
          end else if (slot_free_s) begin
            if_valid_r <= 1'b0;
          end else begin
            state_r <= FETCH;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_r  <= buf_valid_s;
            if_instr_r  <= buf_instr_s;
            if_pc_r     <= buf_pc_s;
            if_pc_4_r   <= buf_pc_s + PC_INCR;
            pc_r        <= pc_next_s;
            imem_addr_r <= pc_next_s;
            imem_req_r  <= 1'b1;
            state_r     <= FETCH;
          end else begin
            state_r <= HOLD;
          end
        end
        DROP: begin
          // Swallow the stale response, then issue the latched target.
          if (ack_s) begin
            imem_addr_r <= pc_r;
            state_r     <= FETCH;
          end else begin
            state_r <= DROP;
          end
        end
        default: begin
          state_r    <= IDLE;
          imem_req_r <= 1'b0;
          if_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign if_valid  = if_valid_r;
  assign if_instr  = if_instr_r;
  assign if_pc     = if_pc_r;
  assign if_pc_4   = if_pc_4_r;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
// Directed bench for fetch_controller. A small memory model returns
// addr ^ 32'hDEAD_0000 and acks either in the request cycle or on the second
// cycle of a request.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;

  logic        wait_mode;
  logic [1:0]  wait_cnt;
  int          errors;
  int          checks;

  localparam logic [31:0] TAG = 32'hDEAD_0000;

  fetch_controller dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_4     (if_pc_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: zero-wait (ack = req) or one wait cycle before ack.
  assign imem_ack   = imem_req && (!wait_mode || (wait_cnt == 2'd1));
  assign imem_rdata = imem_addr ^ TAG;

  // Counts cycles of the current outstanding request.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 2'd0;
    else                              wait_cnt <= wait_cnt + 2'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " req"},   {31'd0, imem_req}, 32'd0);
    check({tag, " addr"},  imem_addr, 32'h0000_0000);
    check({tag, " valid"}, {31'd0, if_valid}, 32'd0);
    check({tag, " instr"}, if_instr,  32'h0000_0000);
    check({tag, " pc"},    if_pc,     32'h0000_0000);
    check({tag, " pc4"},   if_pc_4,   32'h0000_0000);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    wait_mode   = 1'b0;

    // Reset and zero-wait streaming.
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    check("first req", {31'd0, imem_req}, 32'd1);
    check("first addr", imem_addr, 32'h0000_0000);
    check("first valid", {31'd0, if_valid}, 32'd0);
    tick();
    check("s0 addr", imem_addr, 32'h0000_0004);
    check("s0 valid", {31'd0, if_valid}, 32'd1);
    check("s0 pc", if_pc, 32'h0000_0000);
    check("s0 instr", if_instr, 32'h0000_0000 ^ TAG);
    check("s0 pc4", if_pc_4, 32'h0000_0004);
    tick();
    check("s1 addr", imem_addr, 32'h0000_0008);
    check("s1 pc", if_pc, 32'h0000_0004);
    check("s1 valid", {31'd0, if_valid}, 32'd1);

    // Stall three cycles while the word at 8 returns.
    stall = 1'b1;
    tick();
    check("hold pc a", if_pc, 32'h0000_0004);
    check("hold req a", {31'd0, imem_req}, 32'd0);
    check("hold state a", {30'd0, dut.state_r}, 32'd2);
    tick();
    check("hold pc b", if_pc, 32'h0000_0004);
    check("hold req b", {31'd0, imem_req}, 32'd0);
    tick();
    check("hold pc c", if_pc, 32'h0000_0004);
    check("hold valid c", {31'd0, if_valid}, 32'd1);
    stall = 1'b0;
    tick();
    check("drain pc", if_pc, 32'h0000_0008);
    check("drain instr", if_instr, 32'h0000_0008 ^ TAG);
    check("drain addr", imem_addr, 32'h0000_000C);
    check("drain req", {31'd0, imem_req}, 32'd1);
    tick();
    check("resume pc", if_pc, 32'h0000_000C);
    check("resume addr", imem_addr, 32'h0000_0010);

    // Wait-state memory, redirect while 0x10 is outstanding (low bits ignored).
    wait_mode   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("drop valid", {31'd0, if_valid}, 32'd0);
    check("drop addr", imem_addr, 32'h0000_0010);
    check("drop state", {30'd0, dut.state_r}, 32'd3);
    tick();
    check("post drop addr", imem_addr, 32'h0000_0100);
    check("post drop valid", {31'd0, if_valid}, 32'd0);
    tick();
    check("tgt wait valid", {31'd0, if_valid}, 32'd0);
    check("tgt wait addr", imem_addr, 32'h0000_0100);
    tick();
    check("tgt pc", if_pc, 32'h0000_0100);
    check("tgt instr", if_instr, 32'h0000_0100 ^ TAG);
    check("tgt valid", {31'd0, if_valid}, 32'd1);
    check("tgt next addr", imem_addr, 32'h0000_0104);

    // Redirect together with stall while if_valid=1.
    wait_mode   = 1'b0;
    redirect    = 1'b1;
    stall       = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    check("rs valid", {31'd0, if_valid}, 32'd0);
    check("rs addr", imem_addr, 32'h0000_0200);
    tick();
    check("rs pc", if_pc, 32'h0000_0200);
    check("rs next addr", imem_addr, 32'h0000_0204);

    // Wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap pc", if_pc, 32'hFFFF_FFFC);
    check("wrap pc4", if_pc_4, 32'h0000_0000);
    check("wrap next addr", imem_addr, 32'h0000_0000);
    tick();
    check("wrap pc after", if_pc, 32'h0000_0000);
    check("wrap addr after", imem_addr, 32'h0000_0004);

    // Reset while in DROP.
    wait_mode   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    check("pre rst state", {30'd0, dut.state_r}, 32'd3);
    check("pre rst addr", imem_addr, 32'h0000_0004);
    rst = 1'b1;
    tick();
    check_reset("drop reset");
    rst       = 1'b0;
    wait_mode = 1'b0;
    tick();
    check("rerun req", {31'd0, imem_req}, 32'd1);
    check("rerun addr", imem_addr, 32'h0000_0000);

    // Stall with an empty slot does not block the first load.
    stall = 1'b1;
    tick();
    check("empty stall valid", {31'd0, if_valid}, 32'd1);
    check("empty stall pc", if_pc, 32'h0000_0000);
    tick();
    check("busy stall pc", if_pc, 32'h0000_0000);
    check("busy stall req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
